// File: rtl/axis_hdr_insert_param_if.sv
// Stream bundle for the header inserter: payload in, header in, realigned stream out.
interface axis_hdr_insert_param_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int HDR_CNT_WD   = $clog2(DATA_BYTE_WD+1)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [HDR_CNT_WD-1:0]   byte_insert_cnt;
  logic                    ready_insert;

  logic                    err_keep;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out,
           valid_insert, data_insert, byte_insert_cnt,
    output ready_in, valid_out, data_out, keep_out, last_out, ready_insert, err_keep
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out,
           valid_insert, data_insert, byte_insert_cnt,
    input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert, err_keep
  );
endinterface

// File: rtl/axis_hdr_insert_param.sv
// Prepends a 0..DATA_BYTE_WD byte header to each AXI-Stream packet, realigning the payload
// through a byte carry register; registered output with an extra tail beat on overflow.
module axis_hdr_insert_param #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int HDR_CNT_WD   = $clog2(DATA_BYTE_WD+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_hdr_insert_param_if.slave  bus
);
  localparam int B = DATA_BYTE_WD;

  typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WD-1:0]    carry_q, carry_d;
  logic [DATA_WD-1:0]    data_q, data_d, data_raw;
  logic [B-1:0]          keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [HDR_CNT_WD-1:0] hb_q, hb_d;
  logic [HDR_CNT_WD-1:0] tcnt_q, tcnt_d;

  logic                  adv, hdr_hs, pay_hs, bad_keep;
  logic [HDR_CNT_WD-1:0] hb_in, n_in;
  logic [HDR_CNT_WD:0]   tot;
  logic [B-1:0]          keep_n;
  logic [DATA_WD-1:0]    kx_pay, kx_out, pay_m, beat, tail;
  logic [2*DATA_WD-1:0]  cat_sh;

  function automatic logic [B-1:0] msb_ones(input int k);
    logic [B-1:0] m;
    m = '0;
    for (int i = 0; i < B; i++) m[B-1-i] = (i < k);
    return m;
  endfunction

  // Valid byte count is the run of ones from the MSB; anything after it is ignored.
  always_comb begin
    logic run;
    run  = 1'b1;
    n_in = '0;
    for (int i = B-1; i >= 0; i--) begin
      run  = run & bus.keep_in[i];
      n_in = n_in + HDR_CNT_WD'(run);
    end
  end

  assign keep_n   = msb_ones(int'(n_in));
  assign bad_keep = (bus.keep_in != keep_n) || (!bus.last_in && (keep_n != '1));
  assign hb_in    = (bus.byte_insert_cnt > HDR_CNT_WD'(B)) ? HDR_CNT_WD'(B) : bus.byte_insert_cnt;

  for (genvar l = 0; l < B; l++) begin : g_lane
    assign kx_pay[8*l +: 8] = {8{keep_n[l]}};
    assign kx_out[8*l +: 8] = {8{keep_d[l]}};
  end

  // Carry holds its HB live bytes in the low lanes; shifting by the unused lane count
  // drops stale upper bytes and lines the carry up in front of the payload.
  assign pay_m  = bus.data_in & kx_pay;
  assign cat_sh = {carry_q, pay_m} << (8*(B - int'(hb_q)));
  assign beat   = cat_sh[2*DATA_WD-1 -: DATA_WD];
  assign tail   = carry_q << (8*(B - int'(hb_q)));
  assign tot    = {1'b0, hb_q} + {1'b0, n_in};

  assign adv    = !valid_q || bus.ready_out;
  assign hdr_hs = bus.valid_insert && (state_q == IDLE);
  assign pay_hs = bus.valid_in && (state_q == STREAM) && adv;

  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    hb_d     = hb_q;
    tcnt_d   = tcnt_q;
    valid_d  = valid_q;
    data_raw = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    err_d    = err_q | (pay_hs & bad_keep);
    if (adv) begin
      valid_d  = 1'b0;
      data_raw = '0;
      keep_d   = '0;
      last_d   = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (hdr_hs) begin
          hb_d    = hb_in;
          carry_d = bus.data_insert;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pay_hs) begin
          valid_d  = 1'b1;
          data_raw = beat;
          carry_d  = pay_m;
          keep_d   = '1;
          last_d   = 1'b0;
          if (bus.last_in) begin
            if (tot <= (HDR_CNT_WD+1)'(B)) begin
              keep_d  = msb_ones(int'(tot));
              last_d  = 1'b1;
              state_d = IDLE;
            end else begin
              tcnt_d  = HDR_CNT_WD'(tot - (HDR_CNT_WD+1)'(B));
              state_d = TAIL;
            end
          end
        end
      end
      TAIL: begin
        if (adv) begin
          valid_d  = 1'b1;
          data_raw = tail;
          keep_d   = msb_ones(int'(tcnt_q));
          last_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_d = data_raw & kx_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= '0;
      hb_q    <= '0;
      tcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      hb_q    <= hb_d;
      tcnt_q  <= tcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready_in     = (state_q == STREAM) && adv;
  assign bus.ready_insert = (state_q == IDLE);
  assign bus.valid_out    = valid_q;
  assign bus.data_out     = data_q;
  assign bus.keep_out     = keep_q;
  assign bus.last_out     = last_q;
  assign bus.err_keep     = err_q;
endmodule
